// File: rtl/alu_pkg.sv
// Shared ALU types: bitwise op encodings and the sequential logic-unit FSM states.
// Latency: n/a (types only).
// Backpressure: n/a.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_NOT  = 3'b000,
        OP_AND  = 3'b001,
        OP_OR   = 3'b010,
        OP_XOR  = 3'b011,
        OP_NAND = 3'b100,
        OP_NOR  = 3'b101,
        OP_XNOR = 3'b110,
        OP_PASS = 3'b111
    } logic_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } lu_state_t;

endpackage

// File: rtl/logic_slice.sv
// Combinational bitwise operation on one W-bit slice of the operands.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows inputs.
module logic_slice
    import alu_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic_op_t    op,
    output logic [W-1:0] y
);

    always_comb begin
        y = '0;
        case (op)
            OP_NOT:  y = ~a;
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_NAND: y = ~(a & b);
            OP_NOR:  y = ~(a | b);
            OP_XNOR: y = ~(a ^ b);
            OP_PASS: y = a;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/logic_unit_seq.sv
// Multi-cycle bitwise logic unit: WIDTH-bit operands processed CHUNK bits per clock, LSB slice first.
// Latency: N+1 cycles from accepted start to done pulse (N = WIDTH/CHUNK).
// Backpressure: start accepted only in IDLE or DONE; start while busy is dropped, not queued.
module logic_unit_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero
);

    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    lu_state_t        state;
    logic [CW-1:0]    idx;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic_op_t        op_q;
    logic [WIDTH-1:0] work;
    logic [WIDTH-1:0] work_nxt;
    logic             zero_acc;
    logic             zero_nxt;
    logic [CHUNK-1:0] a_sl;
    logic [CHUNK-1:0] b_sl;
    logic [CHUNK-1:0] y_sl;
    int               base;

    always_comb begin
        base     = int'(idx) * CHUNK;
        a_sl     = a_q[base +: CHUNK];
        b_sl     = b_q[base +: CHUNK];
        work_nxt = work;
        work_nxt[base +: CHUNK] = y_sl;
        zero_nxt = zero_acc & (y_sl == '0);
    end

    logic_slice #(
        .W (CHUNK)
    ) u_slice (
        .a  (a_sl),
        .b  (b_sl),
        .op (op_q),
        .y  (y_sl)
    );

    // result/zero are only written on the completion edge, so partial work never leaks out.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            idx      <= '0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= OP_NOT;
            work     <= '0;
            zero_acc <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            zero     <= 1'b1;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_q      <= a;
                        b_q      <= b;
                        op_q     <= logic_op_t'(op);
                        idx      <= '0;
                        work     <= '0;
                        zero_acc <= 1'b1;
                        busy     <= 1'b1;
                        state    <= BUSY;
                    end else begin
                        state <= IDLE;
                    end
                end
                BUSY: begin
                    work     <= work_nxt;
                    zero_acc <= zero_nxt;
                    if (idx == LAST) begin
                        result <= work_nxt;
                        zero   <= zero_nxt;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        state  <= DONE;
                    end else begin
                        idx <= idx + CW'(1);
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_logic_unit_seq.sv
// Directed bench for logic_unit_seq at CHUNK=8 (main), CHUNK=32 and CHUNK=4 (sweep).
module tb_logic_unit_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        start8, start32, start4;
    logic        busy8, busy32, busy4;
    logic        done8, done32, done4;
    logic [31:0] result8, result32, result4;
    logic        zero8, zero32, zero4;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    logic_unit_seq #(.WIDTH(32), .CHUNK(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .op(op), .a(a), .b(b),
        .busy(busy8), .done(done8), .result(result8), .zero(zero8)
    );
    logic_unit_seq #(.WIDTH(32), .CHUNK(32)) dut32 (
        .clk(clk), .rst(rst), .start(start32), .op(op), .a(a), .b(b),
        .busy(busy32), .done(done32), .result(result32), .zero(zero32)
    );
    logic_unit_seq #(.WIDTH(32), .CHUNK(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .op(op), .a(a), .b(b),
        .busy(busy4), .done(done4), .result(result4), .zero(zero4)
    );

    // Launch one op on dut8 and observe a 12-cycle window; lat is the cycle done is seen (start edge = 0).
    task automatic run8(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv,
                        output logic [31:0] res, output logic z,
                        output int lat, output int bcnt, output int dcnt, output int ovl);
        res = 32'hDEADBEEF; z = 1'bx; lat = 0; bcnt = 0; dcnt = 0; ovl = 0;
        @(negedge clk);
        op = o; a = av; b = bv; start8 = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (c == 1) start8 = 1'b0;
            if (busy8) bcnt++;
            if (busy8 && done8) ovl++;
            if (done8) begin
                dcnt++;
                if (lat == 0) begin
                    lat = c; res = result8; z = zero8;
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start8 = 1'b0; start32 = 1'b0; start4 = 1'b0;
        op = 3'b000; a = '0; b = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        n_checks++; if (busy8 !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy8); end
        n_checks++; if (done8 !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done8); end
        n_checks++; if (result8 !== 32'h0) begin n_fail++; $display("FAIL reset_result got %h want 0", result8); end
        n_checks++; if (zero8 !== 1'b1) begin n_fail++; $display("FAIL reset_zero got %b want 1", zero8); end
        n_checks++; if (zero4 !== 1'b1 || busy4 !== 1'b0) begin n_fail++; $display("FAIL reset_dut4 got zero=%b busy=%b want 1 0", zero4, busy4); end
    endtask

    task automatic test_not();
        logic [31:0] r; logic z; int lat, bc, dc, ov;
        run8(3'b000, 32'hCA981547, 32'h5555AAAA, r, z, lat, bc, dc, ov);
        n_checks++; if (lat !== 5) begin n_fail++; $display("FAIL not_latency got %0d want 5", lat); end
        n_checks++; if (r !== 32'h3567EAB8) begin n_fail++; $display("FAIL not_result got %h want 3567eab8", r); end
        n_checks++; if (z !== 1'b0) begin n_fail++; $display("FAIL not_zero got %b want 0", z); end
        n_checks++; if (bc !== 4) begin n_fail++; $display("FAIL not_busy_cycles got %0d want 4", bc); end
        n_checks++; if (dc !== 1) begin n_fail++; $display("FAIL not_done_pulses got %0d want 1", dc); end
        n_checks++; if (ov !== 0) begin n_fail++; $display("FAIL not_busy_done_overlap got %0d want 0", ov); end
    endtask

    task automatic test_xor_and();
        logic [31:0] r; logic z; int lat, bc, dc, ov;
        run8(3'b011, 32'h12345678, 32'h12345678, r, z, lat, bc, dc, ov);
        n_checks++; if (r !== 32'h0) begin n_fail++; $display("FAIL xor_result got %h want 0", r); end
        n_checks++; if (z !== 1'b1) begin n_fail++; $display("FAIL xor_zero got %b want 1", z); end
        run8(3'b001, 32'hFFFF0000, 32'h00FFFF00, r, z, lat, bc, dc, ov);
        n_checks++; if (r !== 32'h00FF0000) begin n_fail++; $display("FAIL and_result got %h want 00ff0000", r); end
        n_checks++; if (z !== 1'b0) begin n_fail++; $display("FAIL and_zero got %b want 0", z); end
        n_checks++; if (lat !== 5) begin n_fail++; $display("FAIL and_latency got %0d want 5", lat); end
    endtask

    task automatic test_start_while_busy();
        int dc = 0; logic [31:0] r = 32'hDEADBEEF;
        @(negedge clk);
        op = 3'b011; a = 32'h0F0F0F0F; b = 32'hFFFF0000; start8 = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (done8) begin dc++; r = result8; end
            if (c <= 3) begin
                a = 32'h11111111 * c; b = 32'h0; op = 3'b111;
            end else begin
                start8 = 1'b0;
            end
        end
        n_checks++; if (r !== 32'hF0F00F0F) begin n_fail++; $display("FAIL ignore_result got %h want f0f00f0f", r); end
        n_checks++; if (dc !== 1) begin n_fail++; $display("FAIL ignore_done_pulses got %0d want 1", dc); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] opa [0:15];
        int dc = 0; int ov = 0;
        for (int i = 0; i < 16; i++) opa[i] = 32'hA5A50000 | i;
        @(negedge clk);
        op = 3'b010; b = 32'h00000F00; a = opa[0]; start8 = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            if (busy8 && done8) ov++;
            if (done8) begin
                dc++;
                n_checks++;
                if (c % 5 != 0) begin
                    n_fail++; $display("FAIL b2b_done_cycle got %0d want multiple of 5", c);
                end else if (result8 !== (opa[c-5] | 32'h00000F00)) begin
                    n_fail++; $display("FAIL b2b_result got %h want %h", result8, opa[c-5] | 32'h00000F00);
                end
            end
            a = opa[c];
            if (c == 15) start8 = 1'b0;
        end
        n_checks++; if (dc !== 3) begin n_fail++; $display("FAIL b2b_done_pulses got %0d want 3", dc); end
        n_checks++; if (ov !== 0) begin n_fail++; $display("FAIL b2b_overlap got %0d want 0", ov); end
        repeat (8) @(negedge clk);
    endtask

    task automatic test_reset_mid_busy();
        int dc = 0;
        logic [31:0] r; logic z; int lat, bc, dcn, ov;
        @(negedge clk);
        op = 3'b000; a = 32'hCA981547; start8 = 1'b1;
        @(posedge clk);
        @(negedge clk); start8 = 1'b0;
        n_checks++; if (busy8 !== 1'b1) begin n_fail++; $display("FAIL rstmid_busy_before got %b want 1", busy8); end
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        n_checks++;
        if (busy8 !== 1'b0 || done8 !== 1'b0 || result8 !== 32'h0 || zero8 !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_state got busy=%b done=%b result=%h zero=%b want 0 0 0 1", busy8, done8, result8, zero8);
        end
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (done8) dc++;
        end
        n_checks++; if (dc !== 0) begin n_fail++; $display("FAIL rstmid_spurious_done got %0d want 0", dc); end
        run8(3'b101, 32'hF0F0F0F0, 32'h0000FFFF, r, z, lat, bc, dcn, ov);
        n_checks++; if (r !== 32'h0F0F0000 || lat !== 5) begin n_fail++; $display("FAIL rstmid_fresh got %h lat %0d want 0f0f0000 lat 5", r, lat); end
    endtask

    task automatic test_param_sweep();
        int lat32 = 0; int lat4 = 0; int bc4 = 0; int bc32 = 0;
        logic [31:0] r32 = 32'hDEADBEEF; logic [31:0] r4 = 32'hDEADBEEF;
        logic z32 = 1'bx; logic z4 = 1'bx;
        @(negedge clk);
        op = 3'b101; a = 32'h0; b = 32'h0; start32 = 1'b1; start4 = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            if (c == 1) begin start32 = 1'b0; start4 = 1'b0; end
            if (busy4) bc4++;
            if (busy32) bc32++;
            if (done32 && lat32 == 0) begin lat32 = c; r32 = result32; z32 = zero32; end
            if (done4 && lat4 == 0) begin lat4 = c; r4 = result4; z4 = zero4; end
        end
        n_checks++; if (lat32 !== 2) begin n_fail++; $display("FAIL sweep32_latency got %0d want 2", lat32); end
        n_checks++; if (r32 !== 32'hFFFFFFFF || z32 !== 1'b0) begin n_fail++; $display("FAIL sweep32_result got %h zero %b want ffffffff 0", r32, z32); end
        n_checks++; if (bc32 !== 1) begin n_fail++; $display("FAIL sweep32_busy_cycles got %0d want 1", bc32); end
        n_checks++; if (lat4 !== 9) begin n_fail++; $display("FAIL sweep4_latency got %0d want 9", lat4); end
        n_checks++; if (r4 !== 32'hFFFFFFFF || z4 !== 1'b0) begin n_fail++; $display("FAIL sweep4_result got %h zero %b want ffffffff 0", r4, z4); end
        n_checks++; if (bc4 !== 8) begin n_fail++; $display("FAIL sweep4_busy_cycles got %0d want 8", bc4); end
    endtask

    initial begin
        test_reset();
        test_not();
        test_xor_and();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid_busy();
        test_param_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
